// File: rtl/fifo_mem.sv
// fifo_mem: FIFO_SIZE x DATA_W register array, one write port, one combinational read port
module fifo_mem #(
  parameter int DATA_W    = 10,
  parameter int FIFO_SIZE = 6,
  parameter int PTR_W     = $clog2(FIFO_SIZE)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [FIFO_SIZE];
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fifo.sv
// fifo: single-clock FIFO with registered read data and a full flag
module fifo #(
  parameter int DATA_W    = 10,
  parameter int FIFO_SIZE = 6
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] read_data,
  output logic              full
);
  localparam int PTR_W = $clog2(FIFO_SIZE);
  localparam int CNT_W = $clog2(FIFO_SIZE + 1);
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rd_word;
  logic              do_push, do_pop;
  assign full    = count == CNT_W'(FIFO_SIZE);
  assign do_pop  = pop && count != '0;
  // a pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
  assign do_push = push && (!full || do_pop);
  fifo_mem #(.DATA_W(DATA_W), .FIFO_SIZE(FIFO_SIZE), .PTR_W(PTR_W)) u_mem (
    .clock  (clock),
    .wr_en  (do_push),
    .wr_addr(wr_ptr),
    .wr_data(data_in),
    .rd_addr(rd_ptr),
    .rd_data(rd_word)
  );
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      read_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr == PTR_W'(FIFO_SIZE - 1) ? '0 : wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr    <= rd_ptr == PTR_W'(FIFO_SIZE - 1) ? '0 : rd_ptr + 1'b1;
        read_data <= rd_word;
      end
      count <= do_push && !do_pop ? count + 1'b1 :
               do_pop && !do_push ? count - 1'b1 : count;
    end
  end
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: scoreboard-driven bench for fifo
module tb_fifo;
  logic       clock = 0;
  logic       rst = 1;
  logic       push = 0;
  logic       pop = 0;
  logic [9:0] data_in = '0;
  logic [9:0] read_data;
  logic       full;
  int         checks = 0;
  int         fails = 0;
  logic [9:0] sb[$];
  logic [9:0] exp_rd = '0;

  fifo #(.DATA_W(10), .FIFO_SIZE(6)) dut (
    .clock(clock), .rst(rst), .push(push), .pop(pop),
    .data_in(data_in), .read_data(read_data), .full(full)
  );

  always #5 clock = ~clock;

  // drives one cycle and updates the scoreboard with what the FIFO should accept
  task automatic drive(input logic p, input logic q, input logic [9:0] d);
    int sz;
    bit popped;
    sz = sb.size();
    popped = q && sz != 0;
    push = p;
    pop = q;
    data_in = d;
    if (popped) exp_rd = sb.pop_front();
    if (p && (sz < 6 || popped)) sb.push_back(d);
    @(negedge clock);
    push = 0;
    pop = 0;
  endtask

  task automatic test_reset;
    #12 rst = 0;
    @(negedge clock);
    checks++; if (read_data !== 10'd0) begin fails++; $display("FAIL reset_rd got %0d want 0", read_data); end
    checks++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %0b want 0", full); end
    drive(0, 1, 0);
    checks++; if (read_data !== 10'd0) begin fails++; $display("FAIL empty_pop_rd got %0d want 0", read_data); end
  endtask

  task automatic test_basic;
    logic [9:0] w [3];
    w = '{10'd101, 10'd202, 10'd303};
    foreach (w[i]) drive(1, 0, w[i]);
    foreach (w[i]) begin
      drive(0, 1, 0);
      checks++; if (read_data !== exp_rd || read_data !== w[i]) begin fails++; $display("FAIL basic_pop%0d got %0d want %0d", i, read_data, w[i]); end
      checks++; if (full !== 1'b0) begin fails++; $display("FAIL basic_full%0d got %0b want 0", i, full); end
    end
  endtask

  task automatic test_empty_pop;
    drive(0, 1, 0);
    checks++; if (read_data !== 10'd303) begin fails++; $display("FAIL empty_hold got %0d want 303", read_data); end
    drive(1, 0, 10'd5);
    drive(0, 1, 0);
    checks++; if (read_data !== 10'd5 || sb.size() != 0) begin fails++; $display("FAIL empty_count got %0d want 5", read_data); end
  endtask

  task automatic test_partial;
    for (int i = 1; i <= 5; i++) drive(1, 0, 10'(11 * i));
    checks++; if (full !== 1'b0) begin fails++; $display("FAIL partial_full got %0b want 0", full); end
    drive(0, 1, 0);
    checks++; if (read_data !== 10'd11) begin fails++; $display("FAIL partial_pop got %0d want 11", read_data); end
    while (sb.size() != 0) begin
      drive(0, 1, 0);
      checks++; if (read_data !== exp_rd) begin fails++; $display("FAIL partial_drain got %0d want %0d", read_data, exp_rd); end
    end
  endtask

  task automatic test_full;
    for (int i = 0; i < 6; i++) begin
      checks++; if (full !== 1'b0) begin fails++; $display("FAIL fill_full%0d got %0b want 0", i, full); end
      drive(1, 0, 10'(300 + i));
    end
    checks++; if (full !== 1'b1) begin fails++; $display("FAIL full_set got %0b want 1", full); end
    drive(1, 0, 10'd99);
    checks++; if (full !== 1'b1 || sb.size() != 6) begin fails++; $display("FAIL full_drop got %0b want 1", full); end
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0);
      checks++; if (read_data !== exp_rd || read_data !== 10'(300 + i)) begin fails++; $display("FAIL full_pop%0d got %0d want %0d", i, read_data, 300 + i); end
      checks++; if (full !== 1'b0) begin fails++; $display("FAIL full_clear%0d got %0b want 0", i, full); end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 6; i++) drive(1, 0, 10'(500 + i));
    drive(1, 1, 10'd77);
    checks++; if (read_data !== 10'd500) begin fails++; $display("FAIL b2b_out got %0d want 500", read_data); end
    checks++; if (full !== 1'b1) begin fails++; $display("FAIL b2b_full got %0b want 1", full); end
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0);
      checks++; if (read_data !== exp_rd) begin fails++; $display("FAIL b2b_drain%0d got %0d want %0d", i, read_data, exp_rd); end
    end
    checks++; if (read_data !== 10'd77) begin fails++; $display("FAIL b2b_last got %0d want 77", read_data); end
    for (int i = 0; i < 6; i++) drive(1, 0, 10'(600 + i));
    drive(1, 1, 10'd700);
    drive(1, 1, 10'd701);
    checks++; if (full !== 1'b1 || read_data !== 10'd601) begin fails++; $display("FAIL burst got full=%0b rd=%0d want 1/601", full, read_data); end
    push = 1;
    pop = 1;
    #2 rst = 1;
    #1;
    checks++; if (read_data !== 10'd0) begin fails++; $display("FAIL async_rd got %0d want 0", read_data); end
    checks++; if (full !== 1'b0) begin fails++; $display("FAIL async_full got %0b want 0", full); end
    push = 0;
    pop = 0;
    sb.delete();
    exp_rd = '0;
    @(negedge clock);
    rst = 0;
    drive(0, 1, 0);
    checks++; if (read_data !== 10'd0) begin fails++; $display("FAIL post_rst_empty got %0d want 0", read_data); end
    drive(1, 0, 10'd42);
    drive(0, 1, 0);
    checks++; if (read_data !== 10'd42) begin fails++; $display("FAIL post_rst_pop got %0d want 42", read_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_pop();
    test_partial();
    test_full();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
